// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu core.
package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_VECTOR = 32'h0000_0000;
    localparam word_t NOP_INSTR    = 32'h0000_0000;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush beats push/pop.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2,
    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_push,
    input  fetch_entry_t    i_data,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [CntW-1:0] o_count,
    output fetch_entry_t    o_head
);

    fetch_entry_t    r_mem [QUEUE_DEPTH];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_do_push = i_push && !i_flush && !i_reset;
    assign w_do_pop  = i_pop && !i_flush && !i_reset;

    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues imem reads, queues words for decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter word_t       RESET_PC    = RESET_VECTOR,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out
);

    localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned OccW = CntW + 1;

    word_t           r_fetch_pc;
    word_t           r_inflight_pc;
    logic            r_inflight;
    word_t           w_fetch_pc_next;
    logic [CntW-1:0] w_count;
    logic [OccW-1:0] w_occ;
    logic            w_pop;
    logic            w_push;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic            w_unused_redirect_lsb;

    assign w_unused_redirect_lsb = ^redirect_pc[1:0];

    assign instr_valid = !reset && !redirect_valid && (w_count != '0);
    assign w_pop       = instr_valid && instr_ready;

    // Occupancy once this cycle's pop and the inflight response have landed.
    assign w_occ = OccW'(w_count) + OccW'(r_inflight) - OccW'(w_pop);

    assign imem_req  = !reset && !redirect_valid && (w_occ < OccW'(QUEUE_DEPTH));
    assign imem_addr = reset ? RESET_PC : r_fetch_pc;

    assign w_push       = r_inflight && !redirect_valid && !reset;
    assign w_push_entry = '{instr: imem_rdata, pc: r_inflight_pc};

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (reset) begin
            w_fetch_pc_next = RESET_PC;
        end else if (redirect_valid) begin
            w_fetch_pc_next = {redirect_pc[31:2], 2'b00};
        end else if (imem_req) begin
            w_fetch_pc_next = r_fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        r_fetch_pc <= w_fetch_pc_next;
        r_inflight <= imem_req;
        if (imem_req) begin
            r_inflight_pc <= r_fetch_pc;
        end
    end

    fetch_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_fetch_queue (
        .i_clock (clock),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_comb begin
        instr_out    = reset ? NOP_INSTR : w_head.instr;
        pc_out       = reset ? 32'h0000_0000 : w_head.pc;
        pc_plus4_out = pc_out + 32'd4;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end of the single-issue MIPS `cpu` core. It sits directly upstream of decode.
- Owns the PC and issues word addresses to a synchronous instruction memory.
- Buffers returned words in a small queue and hands {instruction, PC, PC+4} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards wrong-path words.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
QUEUE_DEPTH, 2, entries in the fetch queue (power of two, >=2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  32  byte address of request, bits [1:0] always 0
imem_rdata  input  32  read data, valid exactly 1 cycle after imem_req
redirect_valid  input  1  execute requests PC change this cycle
redirect_pc  input  32  new fetch address; bits [1:0] ignored
instr_valid  output  1  instr/pc outputs hold a valid instruction
instr_ready  input  1  decode accepts this cycle
instr_out  output  32  instruction word
pc_out  output  32  address of instr_out
pc_plus4_out  output  32  pc_out + 4, modulo 2^32

Behaviour:
- Clock and reset: single clock `clock`; reset is synchronous, active-high, named `reset`.
- State:
  - fetch_pc: next address to request.
  - inflight: 1 bit, a request was issued last cycle.
  - inflight_pc.
  - Queue of QUEUE_DEPTH entries {instr, pc}, with count.
- Reset, sampled on the clock edge:
  - fetch_pc = RESET_PC; inflight = 0; count = 0; queue pointers = 0.
  - While reset is high: imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr_out = pc_out = 0, pc_plus4_out = 4.
- Issue rule, combinational:
  - imem_req = !reset && !redirect_valid && (count + inflight - pop) < QUEUE_DEPTH, where pop = instr_valid && instr_ready.
  - imem_addr = fetch_pc.
  - On issue: fetch_pc += 4, wrapping 32'hFFFF_FFFC to 0; inflight <= 1; inflight_pc <= fetch_pc.
  - Otherwise inflight <= 0.
- Response:
  - When inflight == 1 and no redirect this cycle, push {imem_rdata, inflight_pc} into the queue.
  - The issue rule guarantees the push never overflows.
- Output:
  - instr_valid = (count != 0) && !redirect_valid.
  - instr_out / pc_out come from the queue head; pc_plus4_out = pc_out + 4.
  - Outputs stay stable while instr_valid && !instr_ready.
- Latency and throughput:
  - First instr_valid 2 cycles after reset deasserts: request in cycle 0, push at end of cycle 1, visible in cycle 2.
  - Same 2-cycle latency after a redirect.
  - Sustains 1 instruction/cycle with instr_ready held high and QUEUE_DEPTH = 2.
- Redirect, which has highest priority after reset:
  - In the redirect cycle: queue flushed (count <= 0); inflight response discarded; no pop (instr_valid forced 0); no issue.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Simultaneous redirect and push, or redirect and pop: redirect wins, nothing enters or leaves the queue.
  - Back-to-back redirects: the last one wins; each cycle restarts the 2-cycle latency.
- Stall: with instr_ready = 0, issue continues until count + inflight = QUEUE_DEPTH, then imem_req stays 0. No word is ever dropped or duplicated.
- Reset mid-operation: identical to power-on reset. Queue contents and the inflight response are lost; the imem_rdata arriving the cycle after reset is ignored.

Decomposition:
- Package cpu_pkg:
  - word_t (logic [31:0])
  - RESET_VECTOR constant (default for RESET_PC)
  - fetch_entry_t struct {word_t instr; word_t pc}
  - NOP_INSTR = 32'h0000_0000
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - QUEUE_DEPTH parameter; flush takes priority over push/pop.
- fetch_unit holds PC/issue/inflight logic and instantiates fetch_queue.

Test Plan:
- Reset release, imem model returns addr^32'hA5A5_0000, instr_ready = 1 → imem_addr 0,4,8,… each cycle; instr_valid first high 2 cycles after reset; pc_out 0,4,8,… with instr_out 32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008.
- instr_ready = 0 for 6 cycles from cycle 2 → imem_req drops after addresses 0 and 4; pc_out held at 0; on release pc_out 0,4,8 in consecutive cycles, no gaps or duplicates.
- redirect_valid with redirect_pc = 32'h0000_0103 while queue holds PCs 8,12 → instr_valid 0 in redirect cycle; next imem_addr = 32'h100; next accepted pc_out = 32'h100 two cycles later; PCs 8,12 and the inflight word never appear.
- Redirects on two consecutive cycles to 32'h40 then 32'h80 → no instruction from 32'h40 delivered; first pc_out = 32'h80.
- RESET_PC = 32'hFFFF_FFF8, continuous ready → pc_out FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4_out for FFFF_FFFC equals 0.
- reset asserted for 1 cycle while count = 2 and inflight = 1 → next cycle instr_valid 0, imem_addr = RESET_PC; only RESET_PC-onward instructions delivered afterwards.
